// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Elastic pipeline-stage register with a one-entry skid buffer. It receives
//   words from the upstream stage with a valid/ready handshake and presents
//   them to the downstream stage in strict FIFO order. It can absorb one
//   cycle of downstream back-pressure without losing or duplicating a word.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   flush      synchronous discard of all held words
//   dataIn     upstream word
//   inValid    dataIn carries a valid word
//   inReady    block can accept a word this cycle (registered)
//   dataOut    word presented downstream (registered)
//   outValid   dataOut holds a valid word (registered)
//   outReady   downstream takes dataOut this cycle
//   occupancy  number of held words, 0..2 (registered)
module pipe_stage_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid,
  input  logic             outReady,
  output logic [1:0]       occupancy
);

  // The encoding equals the number of held words, so the state register
  // doubles as the occupancy output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic             accept;
  logic             take;

  // Handshakes use only registered flags, so there is no combinational
  // path from outReady to inReady.
  assign accept = inValid & in_ready_reg;
  assign take   = out_valid_reg & outReady;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // Held words and any concurrent accept are dropped. main keeps its
      // value; dataOut is don't-care while outValid is low.
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_next  = dataIn;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_next = dataIn;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the main one.
            skid_next  = dataIn;
            state_next = FULL;
          end else if (take) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // inReady is low here, so accept cannot occur.
          if (take) begin
            main_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      // Flags are registered from the next state so outputs come straight
      // from flops.
      in_ready_reg  <= (state_next != FULL);
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  assign inReady   = in_ready_reg;
  assign outValid  = out_valid_reg;
  assign dataOut   = main_reg;
  assign occupancy = state_reg;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer
//   Directed bench for pipe_stage_buffer. The driver pushes every word it
//   expects to be accepted into a queue; a monitor pops and compares each
//   time a downstream transfer is about to happen. Directed checks cover
//   flags, occupancy and reset/flush behaviour.
module tb_pipe_stage_buffer;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic [31:0] dataIn;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataOut;
  logic        outValid;
  logic        outReady;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pipe_stage_buffer #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .dataIn   (dataIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady),
    .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer a word for one cycle; the caller states whether the block should
  // be ready. The word is expected downstream only if it is accepted.
  task automatic offer(input logic [31:0] w, input logic exp_ready);
    dataIn  = w;
    inValid = 1'b1;
    chk($sformatf("inReady offering %h", w), {31'd0, inReady}, {31'd0, exp_ready});
    if (exp_ready) exp_q.push_back(w);
    step();
  endtask

  task automatic chk_state(input string name, input logic [1:0] occ,
                           input logic v, input logic r);
    chk({name, " occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    chk({name, " outValid"},  {31'd0, outValid},  {31'd0, v});
    chk({name, " inReady"},   {31'd0, inReady},   {31'd0, r});
  endtask

  // Monitor: a take happens at the next rising edge whenever outValid and
  // outReady are both high and neither reset nor flush overrides it.
  always @(negedge CLK) begin
    if (RST === 1'b0 && flush === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL take: got %h expected no word", dataOut);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dataOut !== e) begin
          errors++;
          $display("FAIL take: got %h expected %h", dataOut, e);
        end else begin
          $display("ok   take: %h", dataOut);
        end
      end
    end
  end

  initial begin
    RST      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b1;
    dataIn   = 32'hDEADBEEF;
    outReady = 1'b0;

    // Reset held for two cycles with a valid word offered.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_state("reset", 2'd0, 1'b0, 1'b1);
      chk("reset dataOut", dataOut, 32'h0);
    end
    RST     = 1'b0;
    inValid = 1'b0;
    step();
    chk_state("post-reset idle", 2'd0, 1'b0, 1'b1);

    // Streaming at one word per cycle.
    outReady = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      offer(32'(w), 1'b1);
      chk($sformatf("stream dataOut %0d", w), dataOut, 32'(w));
      chk_state("stream", 2'd1, 1'b1, 1'b1);
    end
    inValid = 1'b0;
    step();
    chk_state("stream drained", 2'd0, 1'b0, 1'b1);

    // Back-pressure: A then B fill the stage, C is refused until space frees.
    outReady = 1'b0;
    offer(32'hA, 1'b1);
    chk_state("bp after A", 2'd1, 1'b1, 1'b1);
    offer(32'hB, 1'b1);
    chk_state("bp after B", 2'd2, 1'b1, 1'b0);
    chk("bp stalled dataOut", dataOut, 32'hA);
    offer(32'hC, 1'b0);
    chk_state("bp C refused", 2'd2, 1'b1, 1'b0);
    chk("bp still A", dataOut, 32'hA);
    outReady = 1'b1;
    step();
    chk("bp released dataOut", dataOut, 32'hB);
    offer(32'hC, 1'b1);
    chk("bp C presented", dataOut, 32'hC);
    chk_state("bp C", 2'd1, 1'b1, 1'b1);
    inValid = 1'b0;
    step();
    chk_state("bp drained", 2'd0, 1'b0, 1'b1);

    // Simultaneous accept and take while holding one word.
    outReady = 1'b0;
    offer(32'h5, 1'b1);
    chk("sim dataOut 5", dataOut, 32'h5);
    outReady = 1'b1;
    offer(32'h6, 1'b1);
    chk("sim dataOut 6", dataOut, 32'h6);
    chk_state("sim", 2'd1, 1'b1, 1'b1);
    inValid = 1'b0;
    step();
    chk_state("sim drained", 2'd0, 1'b0, 1'b1);

    // Flush while full with a concurrent valid word 9.
    outReady = 1'b0;
    offer(32'h7, 1'b1);
    offer(32'h8, 1'b1);
    chk_state("pre-flush", 2'd2, 1'b1, 1'b0);
    flush   = 1'b1;
    inValid = 1'b1;
    dataIn  = 32'h9;
    exp_q.delete();
    step();
    flush   = 1'b0;
    inValid = 1'b0;
    chk_state("flush", 2'd0, 1'b0, 1'b1);
    outReady = 1'b1;
    step();
    step();
    chk_state("post-flush idle", 2'd0, 1'b0, 1'b1);

    // Reset while full and stalled.
    outReady = 1'b0;
    offer(32'h11, 1'b1);
    offer(32'h22, 1'b1);
    chk_state("pre-reset full", 2'd2, 1'b1, 1'b0);
    inValid = 1'b0;
    RST     = 1'b1;
    exp_q.delete();
    step();
    chk_state("mid reset", 2'd0, 1'b0, 1'b1);
    chk("mid reset dataOut", dataOut, 32'h0);
    RST = 1'b0;
    offer(32'h77, 1'b1);
    chk("after reset first word", dataOut, 32'h77);
    outReady = 1'b1;
    inValid  = 1'b0;
    step();
    step();
    chk_state("final idle", 2'd0, 1'b0, 1'b1);
    chk("scoreboard leftover words", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
